// File: rtl/mult_operand_sequencer_pkg.sv
// Shared types and defaults for the multiplier operand sequencer.
package mult_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} seq_state_t;

    localparam int MULT_N_DEFAULT = 16;

endpackage

// File: rtl/mult_operand_sequencer_fifo.sv
// Synchronous FIFO holding packed operand pairs; DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= wdata;
    end

    assign rdata = mem[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/mult_operand_sequencer.sv
// Feeds queued operand pairs to a shift-add multiplier one job at a time and
// registers each product. Optional accumulator: define MULT_SEQ_ACCUM_EN.
module mult_operand_sequencer
    import mult_pkg::*;
#(
    parameter int N            = MULT_N_DEFAULT,
    parameter int DEPTH        = 4,
    parameter int START_CYCLES = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_a,
    input  logic [N-1:0]             in_b,
    output logic                     mul_start,
    output logic [N-1:0]             mul_a,
    output logic [N-1:0]             mul_b,
    input  logic [2*N-1:0]           mul_p,
    input  logic                     mul_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*N-1:0]           out_p,
    output logic                     busy,
`ifdef MULT_SEQ_ACCUM_EN
    input  logic                     acc_clear,
    output logic [2*N+7:0]           acc,
`endif
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int CW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(START_CYCLES - 1);

    seq_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic             ready_q;
    logic [N-1:0]     mul_a_q, mul_b_q;
    logic [2*N-1:0]   out_p_q;
    logic             out_valid_q;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [2*N-1:0]   fifo_rdata;
    logic             capture, release_out;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;

    sync_fifo #(
        .WIDTH (2*N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   ({in_a, in_b}),
        .rdata   (fifo_rdata),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (fifo_pop)          state_d = ISSUE;
            ISSUE:   if (cnt_q == CNT_LAST) state_d = WAIT;
            WAIT:    if (capture)           state_d = DONE;
            DONE:    if (release_out)       state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // A new job is held back while a product is still waiting for the consumer.
    always_comb begin
        mul_start   = (state_q == ISSUE);
        fifo_pop    = (state_q == IDLE) && !fifo_empty && !out_valid_q;
        capture     = (state_q == WAIT) && mul_ready && !ready_q;
        release_out = (state_q == DONE) && out_valid_q && out_ready;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            out_p_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ready_q <= mul_ready;
            if (fifo_pop) begin
                mul_a_q <= fifo_rdata[2*N-1:N];
                mul_b_q <= fifo_rdata[N-1:0];
                cnt_q   <= '0;
            end else if (state_q == ISSUE) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (capture) begin
                out_p_q     <= mul_p;
                out_valid_q <= 1'b1;
            end else if (release_out) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign out_p     = out_p_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;

`ifdef MULT_SEQ_ACCUM_EN
    logic [2*N+7:0] acc_q;

    // A capture coinciding with a clear restarts the sum from the new product.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else if (capture) begin
            acc_q <= acc_clear ? {8'b0, mul_p} : acc_q + {8'b0, mul_p};
        end else if (acc_clear) begin
            acc_q <= '0;
        end
    end

    assign acc = acc_q;
`endif

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Directed self-checking bench for mult_operand_sequencer with a behavioural
// multiplier model (ready drops on start, rises LAT cycles after start ends).
module tb_mult_operand_sequencer;

    localparam int N   = 16;
    localparam int LAT = 4;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    in_a, in_b;
    logic            mul_start;
    logic [N-1:0]    mul_a, mul_b;
    logic [2*N-1:0]  mul_p = '0;
    logic            mul_ready = 1'b1;
    logic            out_valid;
    logic            out_ready;
    logic [2*N-1:0]  out_p;
    logic            busy;
    logic [2:0]      fifo_count;
`ifdef MULT_SEQ_ACCUM_EN
    logic            acc_clear;
    logic [2*N+7:0]  acc;
`endif

    int compCount = 0;
    int errCount  = 0;

    // Multiplier model controls
    logic            mdlManual = 1'b0;
    logic            manReady  = 1'b1;
    logic [2*N-1:0]  manP      = '0;
    int              mdlCnt    = 0;
    logic [2*N-1:0]  mdlP      = '0;

    mult_operand_sequencer #(.N(N), .DEPTH(4), .START_CYCLES(2)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_p      (mul_p),
        .mul_ready  (mul_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_p      (out_p),
        .busy       (busy),
`ifdef MULT_SEQ_ACCUM_EN
        .acc_clear  (acc_clear),
        .acc        (acc),
`endif
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;

    // Multiplier model updates on the falling edge, away from the DUT's active edge.
    always @(negedge clock) begin
        if (mdlManual) begin
            mul_ready = manReady;
            mul_p     = manP;
        end else if (mul_start) begin
            mul_ready = 1'b0;
            mdlCnt    = LAT;
            mdlP      = {16'b0, mul_a} * {16'b0, mul_b};
        end else if (mdlCnt > 0) begin
            mdlCnt = mdlCnt - 1;
            if (mdlCnt == 0) begin
                mul_p     = mdlP;
                mul_ready = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offer one pair and hold it until the handshake completes (bounded).
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b);
        int n;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        checkOutput("pushAccepted", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for a product, check it, then drain it with one handshake.
    task automatic getProduct(input string tag, input logic [2*N-1:0] exp);
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_p"}, 64'(out_p), 64'(exp));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput({tag, "_drained"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int startSeen;
        int validDrop;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
`ifdef MULT_SEQ_ACCUM_EN
        acc_clear = 1'b0;
`endif
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        $display("[TB] reset values");
        checkOutput("rst_in_ready",   64'(in_ready),   64'd1);
        checkOutput("rst_mul_start",  64'(mul_start),  64'd0);
        checkOutput("rst_mul_a",      64'(mul_a),      64'd0);
        checkOutput("rst_mul_b",      64'(mul_b),      64'd0);
        checkOutput("rst_out_valid",  64'(out_valid),  64'd0);
        checkOutput("rst_out_p",      64'(out_p),      64'd0);
        checkOutput("rst_busy",       64'(busy),       64'd0);
        checkOutput("rst_fifo_count", 64'(fifo_count), 64'd0);

        $display("[TB] single job 1512 x 201");
        applyStimulus(16'd1512, 16'd201);
        checkOutput("j1_count_t",  64'(fifo_count), 64'd1);
        checkOutput("j1_start_t",  64'(mul_start),  64'd0);
        checkOutput("j1_busy_t",   64'(busy),       64'd1);
        tick();
        checkOutput("j1_start_t1", 64'(mul_start),  64'd1);
        checkOutput("j1_mul_a",    64'(mul_a),      64'd1512);
        checkOutput("j1_mul_b",    64'(mul_b),      64'd201);
        checkOutput("j1_count_t1", 64'(fifo_count), 64'd0);
        tick();
        checkOutput("j1_start_t2", 64'(mul_start),  64'd1);
        tick();
        checkOutput("j1_start_t3", 64'(mul_start),  64'd0);
        for (int i = 0; i < 60 && !out_valid; i++) tick();
        checkOutput("j1_valid", 64'(out_valid), 64'd1);
        checkOutput("j1_p",     64'(out_p),     64'd303912);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("j1_valid_held", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("j1_valid_clr", 64'(out_valid), 64'd0);
        checkOutput("j1_busy_end",  64'(busy),      64'd0);

        $display("[TB] burst of five pairs with consumer stalled");
        applyStimulus(16'd207,  16'd810);
        applyStimulus(16'd2000, 16'd660);
        applyStimulus(16'd199,  16'd1120);
        applyStimulus(16'd5000, 16'd500);
        applyStimulus(16'd3,    16'd7);
        checkOutput("burst_full_count",   64'(fifo_count), 64'd4);
        checkOutput("burst_full_inready", 64'(in_ready),   64'd0);
        in_valid = 1'b1;
        in_a     = 16'd100;
        in_b     = 16'd100;
        for (int i = 0; i < 12; i++) tick();
        checkOutput("burst_blocked_count",   64'(fifo_count), 64'd4);
        checkOutput("burst_blocked_inready", 64'(in_ready),   64'd0);
        in_valid = 1'b0;
        getProduct("prod0", 32'd167670);
        applyStimulus(16'd100, 16'd100);

        n_stall: begin
            int n;
            n = 0;
            while (!out_valid && n < 60) begin
                tick();
                n++;
            end
        end
        startSeen = 0;
        validDrop = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (mul_start) startSeen++;
            if (!out_valid) validDrop++;
        end
        checkOutput("stall_no_start",  64'(startSeen), 64'd0);
        checkOutput("stall_valid_held", 64'(validDrop), 64'd0);
        getProduct("prod1", 32'd1320000);
        getProduct("prod2", 32'd222880);
        getProduct("prod3", 32'd2500000);
        getProduct("prod4", 32'd21);
        getProduct("prod5", 32'd10000);

        $display("[TB] mul_ready stuck high on WAIT entry");
        mdlManual = 1'b1;
        manReady  = 1'b1;
        manP      = '0;
        applyStimulus(16'd300, 16'd400);
        for (int i = 0; i < 15; i++) tick();
        checkOutput("stuck_mul_a",   64'(mul_a),     64'd300);
        checkOutput("stuck_mul_b",   64'(mul_b),     64'd400);
        checkOutput("stuck_novalid", 64'(out_valid), 64'd0);
        checkOutput("stuck_busy",    64'(busy),      64'd1);
        checkOutput("stuck_nostart", 64'(mul_start), 64'd0);
        manReady = 1'b0;
        tick();
        checkOutput("stuck_low_novalid", 64'(out_valid), 64'd0);
        manReady = 1'b1;
        manP     = 32'd120000;
        tick();
        checkOutput("stuck_edge_valid", 64'(out_valid), 64'd1);
        getProduct("stuck_prod", 32'd120000);
        mdlManual = 1'b0;

        $display("[TB] reset during WAIT with three queued jobs");
        applyStimulus(16'd11, 16'd13);
        applyStimulus(16'd17, 16'd19);
        applyStimulus(16'd23, 16'd29);
        applyStimulus(16'd31, 16'd37);
        checkOutput("prerst_count", 64'(fifo_count), 64'd3);
        checkOutput("prerst_start", 64'(mul_start),  64'd0);
        checkOutput("prerst_busy",  64'(busy),       64'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_in_ready",   64'(in_ready),   64'd1);
        checkOutput("midrst_mul_start",  64'(mul_start),  64'd0);
        checkOutput("midrst_mul_a",      64'(mul_a),      64'd0);
        checkOutput("midrst_mul_b",      64'(mul_b),      64'd0);
        checkOutput("midrst_out_valid",  64'(out_valid),  64'd0);
        checkOutput("midrst_out_p",      64'(out_p),      64'd0);
        checkOutput("midrst_busy",       64'(busy),       64'd0);
        checkOutput("midrst_fifo_count", 64'(fifo_count), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        out_ready = 1'b1;
        startSeen = 0;
        validDrop = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mul_start) startSeen++;
            if (out_valid) validDrop++;
        end
        out_ready = 1'b0;
        checkOutput("postrst_no_start", 64'(startSeen), 64'd0);
        checkOutput("postrst_no_valid", 64'(validDrop), 64'd0);
        checkOutput("postrst_busy",     64'(busy),      64'd0);

`ifdef MULT_SEQ_ACCUM_EN
        $display("[TB] accumulator");
        checkOutput("acc_rst", 64'(acc), 64'd0);
        applyStimulus(16'd192, 16'd128);
        getProduct("acc_job1", 32'd24576);
        checkOutput("acc_after1", 64'(acc), 64'd24576);
        applyStimulus(16'd1512, 16'd201);
        getProduct("acc_job2", 32'd303912);
        checkOutput("acc_after2", 64'(acc), 64'd328488);
        mdlManual = 1'b1;
        manReady  = 1'b1;
        manP      = '0;
        applyStimulus(16'd1512, 16'd201);
        for (int i = 0; i < 8; i++) tick();
        manReady = 1'b0;
        tick();
        manReady  = 1'b1;
        manP      = 32'd303912;
        acc_clear = 1'b1;
        tick();
        acc_clear = 1'b0;
        checkOutput("acc_clear_capture", 64'(acc), 64'd303912);
        getProduct("acc_job3", 32'd303912);
        mdlManual = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
        $finish;
    end

endmodule
